// File: rtl/vector_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : vector_control_sequencer
// Description : Decode-stage control unit with E/M/WB control pipeline.
//               Vector ALU ops are split into VLEN/LANES lane-beats; decode
//               is back-pressured while the beats are being issued.
//               Optional macro VCS_PERF_COUNTERS_EN builds the retired-
//               instruction and decode-stall performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module vector_control_sequencer #(
    parameter int OPCODE_WIDTH = 4,
    parameter int VLEN         = 4,
    parameter int LANES        = 2,
    parameter int BEAT_W       = (VLEN > 1) ? $clog2(VLEN) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [OPCODE_WIDTH-1:0] opcodeD,
    input  logic                    validD,
    input  logic                    stallIn,
    input  logic                    flushE,
    output logic                    stallD,
    output logic [2:0]              aluControlE,
    output logic                    useInmediateE,
    output logic                    isScalarInstructionE,
    output logic                    isVectorScalarOperationE,
    output logic [BEAT_W-1:0]       laneBaseE,
    output logic                    writeToMemoryEnableM,
    output logic                    outFlagM,
    output logic                    resultSelectorWB,
    output logic                    writeEnableScalarWB,
    output logic                    writeEnableVectorWB,
    output logic [BEAT_W-1:0]       laneBaseWB,
    output logic [15:0]             perfInstrCount,
    output logic [15:0]             perfStallCount
);

    localparam int              c_BEATS     = VLEN / LANES;
    localparam bit              c_MULTI     = (c_BEATS > 1);
    localparam logic [BEAT_W-1:0] c_LANES_W = BEAT_W'(LANES);
    localparam logic [BEAT_W-1:0] c_LAST_BASE = BEAT_W'(VLEN - LANES);

    // Configuration sanity checks, resolved at elaboration.
    if ((VLEN % LANES) != 0) begin : g_bad_lanes
        $error("vector_control_sequencer: VLEN must be a multiple of LANES");
    end
    if (OPCODE_WIDTH < 4) begin : g_bad_opw
        $error("vector_control_sequencer: OPCODE_WIDTH must be at least 4");
    end

    // Control bundle carried from decode into the execute stage.
    typedef struct packed {
        logic [2:0] alu;
        logic       imm;
        logic       scal;
        logic       vs;
        logic       memw;
        logic       outf;
        logic       ressel;
        logic       wes;
        logic       wev;
    } ctrl_t;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEQ  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_stateNext;

    logic [3:0]          w_op;
    ctrl_t               w_dec;
    logic                w_decVec;

    ctrl_t               w_issue;
    logic [BEAT_W-1:0]   w_issueBase;
    logic                w_latch;
    logic [BEAT_W-1:0]   w_baseNext;

    ctrl_t               r_held;
    logic [BEAT_W-1:0]   r_nextBase;

    ctrl_t               r_ctrlE;
    logic [BEAT_W-1:0]   r_baseE;

    logic                r_memwM;
    logic                r_outfM;
    logic                r_resselM;
    logic                r_wesM;
    logic                r_wevM;
    logic [BEAT_W-1:0]   r_baseM;

    logic                r_resselWB;
    logic                r_wesWB;
    logic                r_wevWB;
    logic [BEAT_W-1:0]   r_baseWB;

    assign w_op = opcodeD[3:0];

    // Opcode decode; a bubble decodes as NOP.
    always_comb begin
        w_dec    = '0;
        w_decVec = 1'b0;
        if (validD) begin
            case (w_op)
                4'b0001: begin w_dec.alu = 3'b110; w_dec.scal = 1'b1; w_dec.memw = 1'b1; end
                4'b0010: begin
                    w_dec.alu    = 3'b110;
                    w_dec.scal   = 1'b1;
                    w_dec.ressel = 1'b1;
                    w_dec.wev    = 1'b1;
                end
                4'b0011: begin
                    w_dec.alu  = 3'b111;
                    w_dec.scal = 1'b1;
                    w_dec.imm  = 1'b1;
                    w_dec.wes  = 1'b1;
                end
                4'b0100: begin
                    w_dec.alu    = 3'b110;
                    w_dec.scal   = 1'b1;
                    w_dec.ressel = 1'b1;
                    w_dec.outf   = 1'b1;
                end
                4'b0101: begin w_dec.alu = 3'b000; w_dec.scal = 1'b1; w_dec.wes = 1'b1; end
                4'b0110: begin w_dec.alu = 3'b001; w_dec.scal = 1'b1; w_dec.wes = 1'b1; end
                4'b0111: begin w_dec.alu = 3'b000; w_dec.wev = 1'b1; w_decVec = 1'b1; end
                4'b1000: begin w_dec.alu = 3'b001; w_dec.wev = 1'b1; w_decVec = 1'b1; end
                4'b1001: begin w_dec.alu = 3'b011; w_dec.wev = 1'b1; w_decVec = 1'b1; end
                4'b1010: begin
                    w_dec.alu = 3'b010;
                    w_dec.wev = 1'b1;
                    w_dec.vs  = 1'b1;
                    w_dec.imm = 1'b1;
                    w_decVec  = 1'b1;
                end
                4'b1011: begin w_dec.alu = 3'b001; w_dec.scal = 1'b1; end
                4'b1100, 4'b1101, 4'b1110: begin
                    w_dec.alu  = 3'b111;
                    w_dec.scal = 1'b1;
                    w_dec.imm  = 1'b1;
                end
                default: w_dec = '0;
            endcase
        end
    end

    // Sequencer next state and the bundle/lane base issued into E.
    always_comb begin
        w_stateNext = r_state;
        w_issue     = w_dec;
        w_issueBase = '0;
        w_latch     = 1'b0;
        w_baseNext  = r_nextBase;
        case (r_state)
            S_IDLE: begin
                if (w_decVec && c_MULTI) begin
                    w_latch     = 1'b1;
                    w_stateNext = S_SEQ;
                    w_baseNext  = c_LANES_W;
                end
            end
            S_SEQ: begin
                w_issue     = r_held;
                w_issueBase = r_nextBase;
                if (r_nextBase == c_LAST_BASE) begin
                    w_stateNext = S_IDLE;
                end else begin
                    w_baseNext = r_nextBase + c_LANES_W;
                end
            end
            default: w_stateNext = S_IDLE;
        endcase
        // A flush aborts any sequence in progress, even under a stall.
        if (flushE) begin
            w_stateNext = S_IDLE;
        end
    end

    // Sequencer state register; frozen by a stall unless flushed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else if (flushE || !stallIn) begin
            r_state <= w_stateNext;
        end
    end

    // Latched vector bundle and lane base of the next beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_held     <= '0;
            r_nextBase <= '0;
        end else if (!stallIn && !flushE) begin
            if (w_latch) begin
                r_held <= w_dec;
            end
            r_nextBase <= w_baseNext;
        end
    end

    // Execute stage: flush clears it to NOP, stall holds it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctrlE <= '0;
            r_baseE <= '0;
        end else if (flushE) begin
            r_ctrlE <= '0;
            r_baseE <= '0;
        end else if (!stallIn) begin
            r_ctrlE <= w_issue;
            r_baseE <= w_issueBase;
        end
    end

    // Memory and writeback stages advance together when not stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_memwM    <= 1'b0;
            r_outfM    <= 1'b0;
            r_resselM  <= 1'b0;
            r_wesM     <= 1'b0;
            r_wevM     <= 1'b0;
            r_baseM    <= '0;
            r_resselWB <= 1'b0;
            r_wesWB    <= 1'b0;
            r_wevWB    <= 1'b0;
            r_baseWB   <= '0;
        end else if (!stallIn) begin
            r_memwM    <= r_ctrlE.memw;
            r_outfM    <= r_ctrlE.outf;
            r_resselM  <= r_ctrlE.ressel;
            r_wesM     <= r_ctrlE.wes;
            r_wevM     <= r_ctrlE.wev;
            r_baseM    <= r_baseE;
            r_resselWB <= r_resselM;
            r_wesWB    <= r_wesM;
            r_wevWB    <= r_wevM;
            r_baseWB   <= r_baseM;
        end
    end

    assign stallD                   = stallIn | (r_state == S_SEQ);
    assign aluControlE              = r_ctrlE.alu;
    assign useInmediateE            = r_ctrlE.imm;
    assign isScalarInstructionE     = r_ctrlE.scal;
    assign isVectorScalarOperationE = r_ctrlE.vs;
    assign laneBaseE                = r_baseE;
    assign writeToMemoryEnableM     = r_memwM;
    assign outFlagM                 = r_outfM;
    assign resultSelectorWB         = r_resselWB;
    assign writeEnableScalarWB      = r_wesWB;
    assign writeEnableVectorWB      = r_wevWB;
    assign laneBaseWB               = r_baseWB;

`ifdef VCS_PERF_COUNTERS_EN
    // An issued slot retires only if it is a real instruction's final beat.
    logic        w_issueRetire;
    logic        r_retE;
    logic        r_retM;
    logic [15:0] r_perfInstr;
    logic [15:0] r_perfStall;

    assign w_issueRetire = (r_state == S_IDLE) ? (validD && !(w_decVec && c_MULTI))
                                               : (r_nextBase == c_LAST_BASE);

    // Retire marker travels alongside the control bundle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_retE <= 1'b0;
            r_retM <= 1'b0;
        end else begin
            if (flushE) begin
                r_retE <= 1'b0;
            end else if (!stallIn) begin
                r_retE <= w_issueRetire;
            end
            if (!stallIn) begin
                r_retM <= r_retE;
            end
        end
    end

    // Wrapping counters: retirements into WB and decode-stall cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perfInstr <= 16'h0;
            r_perfStall <= 16'h0;
        end else begin
            if (!stallIn && r_retM) begin
                r_perfInstr <= r_perfInstr + 16'd1;
            end
            if (stallD) begin
                r_perfStall <= r_perfStall + 16'd1;
            end
        end
    end

    assign perfInstrCount = r_perfInstr;
    assign perfStallCount = r_perfStall;
`else
    assign perfInstrCount = 16'h0;
    assign perfStallCount = 16'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vector_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_vector_control_sequencer
// Description : Self-checking bench: decode table vectors, directed multi-
//               cycle sequences and randomized traffic against a beat-level
//               reference model. Built with VLEN=4, LANES=1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vector_control_sequencer;

    localparam int VLEN   = 4;
    localparam int LANES  = 1;
    localparam int BEAT_W = 2;
    localparam int BEATS  = VLEN / LANES;

    logic              clk;
    logic              rst;
    logic [3:0]        opcodeD;
    logic              validD;
    logic              stallIn;
    logic              flushE;
    logic              stallD;
    logic [2:0]        aluControlE;
    logic              useInmediateE;
    logic              isScalarInstructionE;
    logic              isVectorScalarOperationE;
    logic [BEAT_W-1:0] laneBaseE;
    logic              writeToMemoryEnableM;
    logic              outFlagM;
    logic              resultSelectorWB;
    logic              writeEnableScalarWB;
    logic              writeEnableVectorWB;
    logic [BEAT_W-1:0] laneBaseWB;
    logic [15:0]       perfInstrCount;
    logic [15:0]       perfStallCount;

    vector_control_sequencer #(
        .OPCODE_WIDTH(4),
        .VLEN        (VLEN),
        .LANES       (LANES),
        .BEAT_W      (BEAT_W)
    ) u_dut (
        .clk                     (clk),
        .rst                     (rst),
        .opcodeD                 (opcodeD),
        .validD                  (validD),
        .stallIn                 (stallIn),
        .flushE                  (flushE),
        .stallD                  (stallD),
        .aluControlE             (aluControlE),
        .useInmediateE           (useInmediateE),
        .isScalarInstructionE    (isScalarInstructionE),
        .isVectorScalarOperationE(isVectorScalarOperationE),
        .laneBaseE               (laneBaseE),
        .writeToMemoryEnableM    (writeToMemoryEnableM),
        .outFlagM                (outFlagM),
        .resultSelectorWB        (resultSelectorWB),
        .writeEnableScalarWB     (writeEnableScalarWB),
        .writeEnableVectorWB     (writeEnableVectorWB),
        .laneBaseWB              (laneBaseWB),
        .perfInstrCount          (perfInstrCount),
        .perfStallCount          (perfStallCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] alu;
        logic       imm;
        logic       scal;
        logic       vs;
        logic       memw;
        logic       outf;
        logic       ressel;
        logic       wes;
        logic       wev;
    } ctrl_t;

    typedef struct {
        logic [3:0] op;
        logic       valid;
        ctrl_t      exp;
    } vec_t;

    ctrl_t dtab [16];
    vec_t  tbl  [17];
    int    checks   = 0;
    int    failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        opcodeD = 4'h0;
        validD  = 1'b0;
        stallIn = 1'b0;
        flushE  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Present one instruction and let it be accepted at the next edge.
    task automatic issue(input logic [3:0] op);
        @(negedge clk);
        opcodeD = op;
        validD  = 1'b1;
        @(posedge clk);
        #1;
        validD  = 1'b0;
        opcodeD = 4'h0;
    endtask

    function automatic logic [15:0] outs();
        return {stallD, aluControlE, useInmediateE, isScalarInstructionE,
                isVectorScalarOperationE, laneBaseE, writeToMemoryEnableM, outFlagM,
                resultSelectorWB, writeEnableScalarWB, writeEnableVectorWB, laneBaseWB};
    endfunction

    function automatic logic [15:0] exp_outs(input logic s, input ctrl_t e, input int be,
                                             input ctrl_t m, input ctrl_t w, input int bw);
        return {s, e.alu, e.imm, e.scal, e.vs, BEAT_W'(be), m.memw, m.outf,
                w.ressel, w.wes, w.wev, BEAT_W'(bw)};
    endfunction

    // Reference model state (randomized phase).
    ctrl_t mE, mM, mWB, held;
    int    bE, bM, bWB, left, nxt;
    bit    rE, rM, isv, expStallD;
    int    expInstr, expStall;

    initial begin
        // ISA map: alu / imm scal vs memw outf ressel wes wev
        for (int i = 0; i < 16; i++) dtab[i] = '0;
        dtab[1]  = {3'b110, 8'b0_1_0_1_0_0_0_0};
        dtab[2]  = {3'b110, 8'b0_1_0_0_0_1_0_1};
        dtab[3]  = {3'b111, 8'b1_1_0_0_0_0_1_0};
        dtab[4]  = {3'b110, 8'b0_1_0_0_1_1_0_0};
        dtab[5]  = {3'b000, 8'b0_1_0_0_0_0_1_0};
        dtab[6]  = {3'b001, 8'b0_1_0_0_0_0_1_0};
        dtab[7]  = {3'b000, 8'b0_0_0_0_0_0_0_1};
        dtab[8]  = {3'b001, 8'b0_0_0_0_0_0_0_1};
        dtab[9]  = {3'b011, 8'b0_0_0_0_0_0_0_1};
        dtab[10] = {3'b010, 8'b1_0_1_0_0_0_0_1};
        dtab[11] = {3'b001, 8'b0_1_0_0_0_0_0_0};
        dtab[12] = {3'b111, 8'b1_1_0_0_0_0_0_0};
        dtab[13] = {3'b111, 8'b1_1_0_0_0_0_0_0};
        dtab[14] = {3'b111, 8'b1_1_0_0_0_0_0_0};
        for (int i = 0; i < 16; i++) begin
            tbl[i].op    = 4'(i);
            tbl[i].valid = 1'b1;
            tbl[i].exp   = dtab[i];
        end
        tbl[16].op    = 4'h3;
        tbl[16].valid = 1'b0;
        tbl[16].exp   = '0;

        // ---------------- reset state ----------------
        rst     = 1'b1;
        opcodeD = 4'h0;
        validD  = 1'b0;
        stallIn = 1'b0;
        flushE  = 1'b0;
        #2;
        check("reset_outs", 32'(outs()), 32'h0);
        check("reset_perf", {perfInstrCount, perfStallCount}, 32'h0);
        do_reset();

        // ---------------- decode table ----------------
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            opcodeD = tbl[i].op;
            validD  = tbl[i].valid;
            @(posedge clk);
            #1;
            validD  = 1'b0;
            opcodeD = 4'h0;
            check($sformatf("tbl%0d_E", i),
                  {aluControlE, useInmediateE, isScalarInstructionE, isVectorScalarOperationE, laneBaseE},
                  {tbl[i].exp.alu, tbl[i].exp.imm, tbl[i].exp.scal, tbl[i].exp.vs, 2'b00});
            tick();
            check($sformatf("tbl%0d_M", i), {writeToMemoryEnableM, outFlagM},
                  {tbl[i].exp.memw, tbl[i].exp.outf});
            tick();
            check($sformatf("tbl%0d_WB", i),
                  {resultSelectorWB, writeEnableScalarWB, writeEnableVectorWB},
                  {tbl[i].exp.ressel, tbl[i].exp.wes, tbl[i].exp.wev});
            repeat (BEATS + 1) tick();
        end

        // ---------------- ADDI single beat ----------------
        do_reset();
        issue(4'h3);
        check("addi_t1", {stallD, aluControlE, useInmediateE}, {1'b0, 3'b111, 1'b1});
        tick();
        check("addi_t2", stallD, 1'b0);
        tick();
        check("addi_t3", {stallD, writeEnableScalarWB}, {1'b0, 1'b1});

        // ---------------- async reset with ADDI in flight ----------------
        do_reset();
        issue(4'h3);
        rst = 1'b1;
        #1;
        check("async_rst_outs", 32'(outs()), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // ---------------- VADD four beats ----------------
        do_reset();
        issue(4'h7);
        for (int t = 1; t <= 6; t++) begin
            check($sformatf("vadd_t%0d", t),
                  {aluControlE, laneBaseE, stallD, writeEnableVectorWB, laneBaseWB},
                  {3'b000, (t <= 4) ? 2'(t - 1) : 2'd0, 1'(t <= 3),
                   1'(t >= 3), (t >= 3) ? 2'(t - 3) : 2'd0});
            tick();
        end

        // ---------------- VMUL with stall at beat 2 ----------------
        do_reset();
        issue(4'h9);
        tick();
        tick();
        check("vmul_b2", {aluControlE, laneBaseE, writeEnableVectorWB, laneBaseWB},
              {3'b011, 2'd2, 1'b1, 2'd0});
        stallIn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("vmul_hold%0d", k),
                  {stallD, aluControlE, laneBaseE, writeEnableVectorWB, laneBaseWB},
                  {1'b1, 3'b011, 2'd2, 1'b1, 2'd0});
        end
        stallIn = 1'b0;
        tick();
        check("vmul_b3", {stallD, laneBaseE, laneBaseWB}, {1'b0, 2'd3, 2'd1});

        // ---------------- VSUB flushed at beat 1 ----------------
        do_reset();
        issue(4'h8);
        tick();
        check("vsub_b1", {stallD, aluControlE, laneBaseE}, {1'b1, 3'b001, 2'd1});
        flushE  = 1'b1;
        opcodeD = 4'h5;
        validD  = 1'b1;
        tick();
        flushE = 1'b0;
        check("flush_E_nop",
              {stallD, aluControlE, useInmediateE, isScalarInstructionE, laneBaseE, writeToMemoryEnableM},
              8'h00);
        tick();
        validD  = 1'b0;
        opcodeD = 4'h0;
        check("flush_next_add", {stallD, aluControlE, isScalarInstructionE, laneBaseE},
              {1'b0, 3'b000, 1'b1, 2'd0});
        repeat (4) tick();
        check("flush_no_b2_wb", {writeEnableVectorWB, laneBaseWB}, 3'b0_00);

        // ---------------- reset mid-sequence ----------------
        do_reset();
        issue(4'h7);
        tick();
        check("midseq_b1", {stallD, laneBaseE}, {1'b1, 2'd1});
        rst = 1'b1;
        #1;
        check("midseq_rst_outs", 32'(outs()), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        issue(4'h3);
        check("midseq_addi", {stallD, aluControlE, useInmediateE, isScalarInstructionE, laneBaseE},
              {1'b0, 3'b111, 1'b1, 1'b1, 2'd0});
        tick();
        check("midseq_no_beat", {stallD, writeEnableVectorWB, laneBaseE}, 4'h0);

`ifdef VCS_PERF_COUNTERS_EN
        // ---------------- counters: VADD + ADD ----------------
        do_reset();
        @(negedge clk);
        opcodeD = 4'h7;
        validD  = 1'b1;
        @(posedge clk);
        #1;
        opcodeD = 4'h5;
        repeat (3) tick();
        validD  = 1'b0;
        opcodeD = 4'h0;
        repeat (6) tick();
        check("perf_instr", perfInstrCount, 16'd2);
        check("perf_stall", perfStallCount, 16'd3);

        // ---------------- stall counter wrap ----------------
        do_reset();
        @(negedge clk);
        stallIn = 1'b1;
        repeat (65535) @(posedge clk);
        #1;
        check("perf_ffff", perfStallCount, 16'hFFFF);
        tick();
        check("perf_wrap", perfStallCount, 16'h0000);
        stallIn = 1'b0;
`endif

        // ---------------- randomized traffic ----------------
        do_reset();
        mE = '0; mM = '0; mWB = '0; held = '0;
        bE = 0; bM = 0; bWB = 0; left = 0; nxt = 0;
        rE = 1'b0; rM = 1'b0;
        expInstr = 0;
        expStall = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            opcodeD = 4'($urandom_range(0, 15));
            validD  = ($urandom_range(0, 9) != 0);
            stallIn = ($urandom_range(0, 9) == 0);
            flushE  = ($urandom_range(0, 19) == 0);
            #1;
            expStallD = stallIn || (left > 0);
            check($sformatf("rand%0d", cyc), 32'(outs()),
                  32'(exp_outs(expStallD, mE, bE, mM, mWB, bWB)));
            @(posedge clk);
            if (expStallD) expStall++;
            if (!stallIn) begin
                if (rM) expInstr++;
                mWB = mM; bWB = bM;
                mM  = mE; bM  = bE; rM = rE;
            end
            if (flushE) begin
                mE = '0; bE = 0; rE = 1'b0; left = 0;
            end else if (!stallIn) begin
                if (left > 0) begin
                    mE = held;
                    bE = nxt * LANES;
                    nxt++;
                    left--;
                    rE = (left == 0);
                end else begin
                    mE  = validD ? dtab[opcodeD] : ctrl_t'('0);
                    bE  = 0;
                    isv = validD && (opcodeD >= 4'd7) && (opcodeD <= 4'd10);
                    if (isv && (BEATS > 1)) begin
                        held = mE;
                        left = BEATS - 1;
                        nxt  = 1;
                        rE   = 1'b0;
                    end else begin
                        rE = validD;
                    end
                end
            end
        end
        @(negedge clk);
        stallIn = 1'b0;
        flushE  = 1'b0;
        validD  = 1'b0;
`ifdef VCS_PERF_COUNTERS_EN
        check("rand_perf_instr", perfInstrCount, 16'(expInstr));
        check("rand_perf_stall", perfStallCount, 16'(expStall));
`else
        check("rand_perf_off", {perfInstrCount, perfStallCount}, 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
